// File: rtl/system_pkg.sv
// Shared types and helpers for the system_timesync command unit and its
// latch capture channels.
package system_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_ARGS,
        SYNC_APPLY,
        EMIT,
        END
    } state_t;

    // Bit positions inside the GET_LATCH status word.
    localparam int ST_VALID_BIT = 0;
    localparam int ST_OVF_BIT   = 1;

    // Cycles between a pin edge and the time load taking effect:
    // synchroniser stages, edge detect/capture, then the registered load.
    function automatic int sync_ofs(input int stages);
        return stages + 2;
    endfunction

endpackage

// File: rtl/system_timesync_latch_capture.sv
// One timesync latch channel: synchroniser, selectable edge detector,
// captured timestamp and sticky valid/overflow flags.
module latch_capture
    import system_pkg::*;
#(
    parameter int TW          = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          latch_in,
    input  logic          rising,
    input  logic          clr,
    input  logic [TW-1:0] time_in,
    output logic [TW-1:0] lat_time,
    output logic          valid,
    output logic          overflow
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_det;

    assign edge_det = rising ? (sync_q[SYNC_STAGES-1] & ~prev_q)
                             : (~sync_q[SYNC_STAGES-1] & prev_q);

    // Bring the asynchronous pin into the clock domain and keep the last level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], latch_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Capture the time on an edge; a capture beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_time <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (edge_det) begin
            lat_time <= time_in;
            valid    <= 1'b1;
            overflow <= clr ? 1'b0 : (overflow | valid);
        end else if (clr) begin
            valid    <= 1'b0;
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/system_timesync.sv
// System command unit: GET_VERSION, GET_TIME, SYNC_TIME, GET_LATCH and
// CONFIG_LATCH over the dispatcher cmd/arg/param bus, with NUM_LATCH
// timesync latch channels.
// Optional feature macro: SYSTEM_TIMESYNC_AUTOREPORT_EN (adds invol_req /
// invol_grant and unsolicited latch reports).
//
// state      | meaning
// IDLE       | wait for a command (or an auto-report grant)
// SYNC_ARGS  | collect TIME_WORDS reference words, LSW first
// SYNC_APPLY | compute and strobe the new system time
// EMIT       | one response word per cycle
// END        | response code on param_data with cmd_done
module system_timesync
    import system_pkg::*;
#(
    parameter int                  CMD_BITS         = 8,
    parameter logic [CMD_BITS-1:0] CMD_GET_VERSION  = '0,
    parameter logic [CMD_BITS-1:0] RSP_GET_VERSION  = '0,
    parameter logic [CMD_BITS-1:0] CMD_GET_TIME     = '0,
    parameter logic [CMD_BITS-1:0] RSP_GET_TIME     = '0,
    parameter logic [CMD_BITS-1:0] CMD_SYNC_TIME    = '0,
    parameter logic [CMD_BITS-1:0] CMD_GET_LATCH    = '0,
    parameter logic [CMD_BITS-1:0] RSP_GET_LATCH    = '0,
    parameter logic [CMD_BITS-1:0] CMD_CONFIG_LATCH = '0,
    parameter logic [31:0]         VERSION          = 32'd2,
    parameter int                  NUM_LATCH        = 4,
    parameter int                  TIME_WORDS       = 2,
    parameter int                  SYNC_STAGES      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              arg_data,
    output logic                     arg_advance,
    input  logic [CMD_BITS-1:0]      cmd,
    input  logic                     cmd_ready,
    output logic                     cmd_done,
    output logic [31:0]              param_data,
    output logic                     param_write,
    input  logic [32*TIME_WORDS-1:0] time_in,
    output logic [32*TIME_WORDS-1:0] time_out,
    output logic                     time_out_en,
    input  logic [NUM_LATCH-1:0]     latch_in
`ifdef SYSTEM_TIMESYNC_AUTOREPORT_EN
    ,
    output logic                     invol_req,
    input  logic                     invol_grant
`endif
);

    localparam int          TW  = 32 * TIME_WORDS;
    localparam logic [TW-1:0] OFS = TW'(sync_ofs(SYNC_STAGES));

    state_t                state;
    logic [NUM_LATCH-1:0]  edge_sel;
    logic [NUM_LATCH-1:0]  clr_v;
    logic [31:0]           valid_all;
    logic [31:0]           ovf_all;
    logic [TW-1:0]         lat_all [32];
    logic [TW-1:0]         out_buf;
    logic [TW-1:0]         ref_q;
    logic [7:0]            left_q;
    logic [7:0]            wcnt_q;
    logic [4:0]            ch_q;
    logic                  ch_ok_q;
    logic [CMD_BITS-1:0]   rsp_q;
    logic                  go;
    logic                  arg_ok;
    logic [4:0]            arg_ch;
    logic                  valid_sel;
    logic [31:0]           st_word;
    logic                  auto_take;
    logic [4:0]            pend_ch;

    // A command is accepted only in IDLE once the previous cmd_done is gone;
    // channel numbers wider than the table are simply out of range.
    assign go        = rst_n && (state == IDLE) && cmd_ready && !cmd_done;
    assign arg_ok    = arg_data < 32'(NUM_LATCH);
    assign arg_ch    = arg_data[4:0];
    assign valid_sel = ch_ok_q && valid_all[ch_q];

    // Channels are padded to 32 so any 5-bit index reads zeros when unused.
    for (genvar i = 0; i < 32; i++) begin : g_ch
        if (i < NUM_LATCH) begin : g_on
            latch_capture #(
                .TW          (TW),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_cap (
                .clk      (clk),
                .rst_n    (rst_n),
                .latch_in (latch_in[i]),
                .rising   (edge_sel[i]),
                .clr      (clr_v[i]),
                .time_in  (time_in),
                .lat_time (lat_all[i]),
                .valid    (valid_all[i]),
                .overflow (ovf_all[i])
            );
        end else begin : g_off
            assign lat_all[i]   = '0;
            assign valid_all[i] = 1'b0;
            assign ovf_all[i]   = 1'b0;
        end
    end

    // Arguments are consumed on dispatch of arg-taking commands and while collecting ref.
    always_comb begin
        arg_advance = 1'b0;
        if (rst_n && state == SYNC_ARGS)
            arg_advance = 1'b1;
        else if (go && (cmd == CMD_SYNC_TIME || cmd == CMD_GET_LATCH || cmd == CMD_CONFIG_LATCH))
            arg_advance = 1'b1;
    end

    // Status word for the addressed channel and per-channel clear requests.
    always_comb begin
        st_word = '0;
        if (arg_ok) begin
            st_word[ST_VALID_BIT] = valid_all[arg_ch];
            st_word[ST_OVF_BIT]   = ovf_all[arg_ch];
        end
        for (int i = 0; i < NUM_LATCH; i++) begin
            clr_v[i] = (go && cmd == CMD_GET_LATCH && arg_data == 32'(i)) ||
                       (state == SYNC_APPLY && valid_sel && ch_q == 5'(i));
        end
    end

`ifdef SYSTEM_TIMESYNC_AUTOREPORT_EN
    logic [NUM_LATCH-1:0] reported_q;
    logic [NUM_LATCH-1:0] pend;

    assign pend      = valid_all[NUM_LATCH-1:0] & ~reported_q;
    assign invol_req = (state == IDLE) && !cmd_done && (|pend);
    assign auto_take = invol_req && invol_grant && !go;

    // Lowest pending channel wins the report.
    always_comb begin
        pend_ch = '0;
        for (int i = NUM_LATCH - 1; i >= 0; i--)
            if (pend[i]) pend_ch = 5'(i);
    end

    // A channel is reported once per valid period; a clear re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reported_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LATCH; i++) begin
                if (clr_v[i])
                    reported_q[i] <= 1'b0;
                else if (auto_take && pend_ch == 5'(i))
                    reported_q[i] <= 1'b1;
            end
        end
    end
`else
    assign auto_take = 1'b0;
    assign pend_ch   = '0;
`endif

    // Command FSM with registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            edge_sel    <= '0;
            out_buf     <= '0;
            ref_q       <= '0;
            left_q      <= '0;
            wcnt_q      <= '0;
            ch_q        <= '0;
            ch_ok_q     <= 1'b0;
            rsp_q       <= '0;
            cmd_done    <= 1'b0;
            param_data  <= '0;
            param_write <= 1'b0;
            time_out    <= '0;
            time_out_en <= 1'b0;
        end else begin
            cmd_done    <= 1'b0;
            param_data  <= '0;
            param_write <= 1'b0;
            time_out_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if (cmd == CMD_GET_VERSION) begin
                            param_data  <= VERSION;
                            param_write <= 1'b1;
                            left_q      <= '0;
                            rsp_q       <= RSP_GET_VERSION;
                            state       <= EMIT;
                        end else if (cmd == CMD_GET_TIME) begin
                            param_data  <= time_in[31:0];
                            param_write <= 1'b1;
                            out_buf     <= time_in >> 32;
                            left_q      <= 8'(TIME_WORDS - 1);
                            rsp_q       <= RSP_GET_TIME;
                            state       <= EMIT;
                        end else if (cmd == CMD_SYNC_TIME) begin
                            ch_q    <= arg_ch;
                            ch_ok_q <= arg_ok;
                            wcnt_q  <= '0;
                            state   <= SYNC_ARGS;
                        end else if (cmd == CMD_GET_LATCH) begin
                            param_data  <= st_word;
                            param_write <= 1'b1;
                            out_buf     <= arg_ok ? lat_all[arg_ch] : '0;
                            left_q      <= 8'(TIME_WORDS);
                            rsp_q       <= RSP_GET_LATCH;
                            state       <= EMIT;
                        end else if (cmd == CMD_CONFIG_LATCH) begin
                            edge_sel <= arg_data[NUM_LATCH-1:0];
                            cmd_done <= 1'b1;
                        end
                    end else if (auto_take) begin
                        param_data  <= 32'(pend_ch);
                        param_write <= 1'b1;
                        out_buf     <= lat_all[pend_ch];
                        left_q      <= 8'(TIME_WORDS);
                        rsp_q       <= RSP_GET_LATCH;
                        state       <= EMIT;
                    end
                end
                SYNC_ARGS: begin
                    ref_q  <= TW'({arg_data, ref_q} >> 32);
                    wcnt_q <= wcnt_q + 8'd1;
                    if (wcnt_q == 8'(TIME_WORDS - 1))
                        state <= SYNC_APPLY;
                end
                SYNC_APPLY: begin
                    if (valid_sel) begin
                        time_out    <= time_in - lat_all[ch_q] + ref_q + OFS;
                        time_out_en <= 1'b1;
                    end
                    cmd_done <= 1'b1;
                    state    <= IDLE;
                end
                EMIT: begin
                    if (left_q != 8'd0) begin
                        param_data  <= out_buf[31:0];
                        param_write <= 1'b1;
                        out_buf     <= out_buf >> 32;
                        left_q      <= left_q - 8'd1;
                    end else begin
                        param_data <= 32'(rsp_q);
                        cmd_done   <= 1'b1;
                        state      <= END;
                    end
                end
                END:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_system_timesync.sv
// Directed bench for system_timesync with distinct command codes.
module tb_system_timesync;

    localparam logic [7:0] C_VER = 8'h01, R_VER = 8'h81;
    localparam logic [7:0] C_TIM = 8'h02, R_TIM = 8'h82;
    localparam logic [7:0] C_SYN = 8'h03;
    localparam logic [7:0] C_LAT = 8'h04, R_LAT = 8'h84;
    localparam logic [7:0] C_CFG = 8'h05;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] arg_data;
    logic        arg_advance;
    logic [7:0]  cmd;
    logic        cmd_ready;
    logic        cmd_done;
    logic [31:0] param_data;
    logic        param_write;
    logic [63:0] time_in;
    logic [63:0] time_out;
    logic        time_out_en;
    logic [3:0]  latch_in;

    system_timesync #(
        .CMD_BITS(8),
        .CMD_GET_VERSION(C_VER), .RSP_GET_VERSION(R_VER),
        .CMD_GET_TIME(C_TIM),    .RSP_GET_TIME(R_TIM),
        .CMD_SYNC_TIME(C_SYN),
        .CMD_GET_LATCH(C_LAT),   .RSP_GET_LATCH(R_LAT),
        .CMD_CONFIG_LATCH(C_CFG),
        .VERSION(32'd2), .NUM_LATCH(4), .TIME_WORDS(2), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arg_data(arg_data), .arg_advance(arg_advance),
        .cmd(cmd), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
        .param_data(param_data), .param_write(param_write),
        .time_in(time_in), .time_out(time_out), .time_out_en(time_out_en),
        .latch_in(latch_in)
    );

    always #5 clk = ~clk;

    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] a_buf [4];
    logic [31:0] rx [$];
    logic [31:0] rsp;
    int          n_en, n_adv, last_w_k, done_k;
    logic [63:0] tout;
    bit          done;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx.size()) ? rx[i] : 32'hDEAD_BEEF;
    endfunction

    // Issue one command, feed args on arg_advance, gather words until cmd_done.
    task automatic run_cmd(input string tag, input logic [7:0] c);
        int ai;
        bit adv;
        rx.delete();
        n_en = 0; n_adv = 0; done = 0; rsp = '0; tout = '0;
        last_w_k = -1; done_k = -1;
        @(negedge clk);
        cmd = c; cmd_ready = 1'b1; ai = 0; arg_data = a_buf[0];
        for (int k = 0; k < 40 && !done; k++) begin
            #1 adv = arg_advance;
            @(negedge clk);
            if (adv) begin
                n_adv++; ai++;
                arg_data = (ai < 4) ? a_buf[ai] : 32'h0;
            end
            if (param_write) begin rx.push_back(param_data); last_w_k = k; end
            if (time_out_en) begin n_en++; tout = time_out; end
            if (cmd_done) begin done = 1; done_k = k; rsp = param_data; cmd_ready = 1'b0; end
        end
        cmd_ready = 1'b0;
        check_eq({tag, ".done"}, 64'(done), 64'd1);
    endtask

    task automatic get_latch(input string tag, input logic [31:0] ch);
        a_buf[0] = ch;
        run_cmd(tag, C_LAT);
    endtask

    task automatic pulse(input int ch, input logic [63:0] t);
        time_in = t;
        @(negedge clk) latch_in[ch] = 1'b1;
        repeat (4) @(negedge clk);
        latch_in[ch] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd = '0; cmd_ready = 1'b0; arg_data = '0; time_in = '0; latch_in = '0;
        for (int i = 0; i < 4; i++) a_buf[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst.param_write", 64'(param_write), 64'd0);
        check_eq("rst.cmd_done",    64'(cmd_done),    64'd0);
        check_eq("rst.param_data",  64'(param_data),  64'd0);
        check_eq("rst.time_out_en", 64'(time_out_en), 64'd0);
        check_eq("rst.time_out",    time_out,         64'd0);
        check_eq("rst.arg_advance", 64'(arg_advance), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd("ver", C_VER);
        check_eq("ver.nwords", 64'(rx.size()), 64'd1);
        check_eq("ver.word0",  64'(rx_at(0)), 64'd2);
        check_eq("ver.rsp",    64'(rsp), 64'(R_VER));
        check_eq("ver.done_after_word", 64'(done_k), 64'(last_w_k + 1));
        check_eq("ver.nadv",   64'(n_adv), 64'd0);

        a_buf[0] = 32'h1;
        run_cmd("cfg", C_CFG);
        check_eq("cfg.nwords", 64'(rx.size()), 64'd0);
        check_eq("cfg.nadv",   64'(n_adv), 64'd1);

        pulse(0, 64'd1000);
        get_latch("lat0", 32'd0);
        check_eq("lat0.status", 64'(rx_at(0)), 64'd1);
        check_eq("lat0.t_lo",   64'(rx_at(1)), 64'd1000);
        check_eq("lat0.t_hi",   64'(rx_at(2)), 64'd0);
        check_eq("lat0.rsp",    64'(rsp), 64'(R_LAT));
        check_eq("lat0.nadv",   64'(n_adv), 64'd1);
        get_latch("lat0b", 32'd0);
        check_eq("lat0b.status", 64'(rx_at(0)), 64'd0);

        pulse(2, 64'd200);
        pulse(2, 64'd300);
        get_latch("lat2", 32'd2);
        check_eq("lat2.status", 64'(rx_at(0)), 64'd3);
        check_eq("lat2.t_lo",   64'(rx_at(1)), 64'd300);

        pulse(1, 64'd500);
        time_in = 64'd600;
        a_buf[0] = 32'd1; a_buf[1] = 32'hFFFF_FFFF; a_buf[2] = 32'h1; a_buf[3] = 32'h0;
        run_cmd("sync1", C_SYN);
        check_eq("sync1.n_en", 64'(n_en), 64'd1);
        check_eq("sync1.time", tout, 64'h0000_0002_0000_0067);
        check_eq("sync1.nadv", 64'(n_adv), 64'd3);
        @(negedge clk);
        check_eq("sync1.en_drop", 64'(time_out_en), 64'd0);
        get_latch("lat1", 32'd1);
        check_eq("lat1.status", 64'(rx_at(0)), 64'd0);

        a_buf[0] = 32'd3; a_buf[1] = 32'd5; a_buf[2] = 32'd0;
        run_cmd("sync3", C_SYN);
        check_eq("sync3.n_en", 64'(n_en), 64'd0);
        a_buf[0] = 32'd7;
        run_cmd("sync7", C_SYN);
        check_eq("sync7.n_en", 64'(n_en), 64'd0);
        check_eq("sync7.nadv", 64'(n_adv), 64'd3);
        get_latch("lat7", 32'd7);
        check_eq("lat7.status", 64'(rx_at(0)), 64'd0);
        check_eq("lat7.t_lo",   64'(rx_at(1)), 64'd0);
        check_eq("lat7.t_hi",   64'(rx_at(2)), 64'd0);

        time_in = 64'h0000_0005_0000_0007;
        run_cmd("time", C_TIM);
        check_eq("time.nwords", 64'(rx.size()), 64'd2);
        check_eq("time.w0",     64'(rx_at(0)), 64'd7);
        check_eq("time.w1",     64'(rx_at(1)), 64'd5);
        check_eq("time.rsp",    64'(rsp), 64'(R_TIM));

        begin : mid_reset
            bit seen;
            seen = 0;
            time_in = 64'h0000_0009_0000_0008;
            @(negedge clk);
            cmd = C_TIM; cmd_ready = 1'b1;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (param_write) seen = 1;
            end
            check_eq("mrst.emit_seen", 64'(seen), 64'd1);
            rst_n = 1'b0;
            #1;
            check_eq("mrst.param_write", 64'(param_write), 64'd0);
            check_eq("mrst.cmd_done",    64'(cmd_done),    64'd0);
            cmd_ready = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        run_cmd("time2", C_TIM);
        check_eq("time2.w0",  64'(rx_at(0)), 64'd8);
        check_eq("time2.w1",  64'(rx_at(1)), 64'd9);
        check_eq("time2.rsp", 64'(rsp), 64'(R_TIM));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/system_timesync.md
Name: system_timesync

Overview:
- Successor to the single-latch system command block.
- Handles GET_VERSION and GET_TIME, and adds NUM_LATCH independent timesync latch inputs with per-channel edge polarity and sticky valid/overflow status.
- Time width is parametrised; SYNC_TIME is per channel.
- Sits on the command dispatcher bus (cmd/arg/param) beside other command units, and drives the global system time counter through time_out/time_out_en.

Parameters:
- CMD_BITS, 8, command code width
- CMD_GET_VERSION / RSP_GET_VERSION, 0 / 0, version command and response codes
- CMD_GET_TIME / RSP_GET_TIME, 0 / 0, time read command and response codes
- CMD_SYNC_TIME, 0, time sync command code
- CMD_GET_LATCH / RSP_GET_LATCH, 0 / 0, latch read command and response codes
- CMD_CONFIG_LATCH, 0, edge polarity configuration command code
- VERSION, 2, value returned by GET_VERSION
- NUM_LATCH, 4, number of latch channels (1..32)
- TIME_WORDS, 2, time width in 32-bit words; TW = 32*TIME_WORDS
- SYNC_STAGES, 2, synchroniser depth (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arg_data  in  32  current command argument
- arg_advance  out  1  argument consumed this cycle
- cmd  in  CMD_BITS  command code
- cmd_ready  in  1  command valid
- cmd_done  out  1  one-cycle completion pulse
- param_data  out  32  response word / response code
- param_write  out  1  response word valid
- time_in  in  TW  current system time
- time_out  out  TW  new system time
- time_out_en  out  1  one-cycle load strobe for time_out
- latch_in  in  NUM_LATCH  asynchronous timesync pulses

Behaviour:
Reset (rst_n=0, async) — all outputs 0, and:
- state = IDLE
- latched times 0, valid/overflow 0
- edge_sel 0 (falling edge on every channel)
- synchronisers cleared

Latch capture, per channel:
- SYNC_STAGES-flop synchroniser, then an edge detector selected by edge_sel[i] (1 = rising).
- On a detected edge, lat_time[i] <= time_in.
- If valid[i] is already 1, overflow[i] <= 1; valid[i] <= 1.
- Captures run continuously, independent of the FSM.

Sync offset:
- OFS = SYNC_STAGES + 2 (synchroniser stages + edge/capture + one-cycle load delay).

Arithmetic:
- Modulo 2^TW; wrap-around is silent.

Argument handling:
- arg_advance = 1 only in cycles that consume arg_data: IDLE with cmd_ready on SYNC/GET_LATCH/CONFIG, and SYNC_ARGS.
- Multi-word values are LSW first.

FSM states and transitions:
- IDLE & cmd_ready, dispatch on cmd:
  - GET_VERSION: emit one word VERSION, then END.
  - GET_TIME: snapshot time_in; emit TIME_WORDS words, then END.
  - SYNC_TIME: arg0 = channel; go to SYNC_ARGS and collect TIME_WORDS words into ref.
  - GET_LATCH: arg0 = channel; emit status word {30'b0, overflow, valid}, then TIME_WORDS words of lat_time; clear valid/overflow of that channel on the status-word cycle; then END.
  - CONFIG_LATCH: edge_sel <= arg0[NUM_LATCH-1:0]; cmd_done next cycle; no response words, param_write stays 0.
  - Unknown cmd: ignored, no cmd_done.
- SYNC_ARGS:
  - When the last word arrives, go to SYNC_APPLY.
  - If valid[ch]: time_out <= time_in - lat_time[ch] + ref + OFS; time_out_en = 1 for one cycle; clear valid[ch] and overflow[ch].
  - Else: no strobe.
  - Either case: cmd_done, back to IDLE.
- EMIT: one word per cycle with param_write = 1.
- END (one cycle): param_write = 0; param_data = the matching RSP_* code; cmd_done = 1; then IDLE.

Boundary conditions:
- Channel index >= NUM_LATCH: GET_LATCH returns status 0 and time words 0; SYNC_TIME produces no strobe. Neither hangs.
- Capture in the same cycle as a clear: capture wins; valid = 1, overflow = 0.
- Capture during SYNC_APPLY: the pre-edge lat_time is used; the new capture remains valid afterwards.
- cmd_ready outside IDLE: ignored; the dispatcher holds it until cmd_done.
- Reset mid-command: abort immediately; no cmd_done; outputs return to 0.

Optional Feature:
Macro SYSTEM_TIMESYNC_AUTOREPORT_EN.
- Defined:
  - Adds ports invol_req (out, 1) and invol_grant (in, 1).
  - From IDLE, any channel with valid and !reported raises invol_req; lowest index wins.
  - On invol_grant, emit {channel} followed by TIME_WORDS time words, then END with RSP_GET_LATCH.
  - Sets reported[i]; valid is not cleared.
  - A host command arriving in the same cycle as invol_grant has priority; invol_req is held.
- Undefined: no such ports; latch data is readable only through GET_LATCH.

Decomposition:
- Package system_pkg:
  - FSM state enum: IDLE, SYNC_ARGS, SYNC_APPLY, EMIT, END
  - Status-word bit positions
  - OFS formula helper
- Sub-module latch_capture: synchroniser, edge select, capture register and valid/overflow flags for one channel; instantiated NUM_LATCH times via generate.

Test Plan:
- Reset release, then GET_VERSION → one word 2 with param_write = 1, next cycle param_data = RSP_GET_VERSION with cmd_done = 1.
- CONFIG_LATCH arg 0x1; rising pulse on latch_in[0] while time_in = 1000 → GET_LATCH ch0 returns status 0x1, words 1000 and 0; a second GET_LATCH returns status 0x0.
- Two edges on ch2 before a read → status 0x3, time word is the second capture.
- Ch1 captured at 500, time_in = 600 at apply, SYNC_TIME ch1 ref = 0x0000_0001_FFFF_FFFF → time_out = 0x2_0000_0067, one-cycle time_out_en.
- SYNC_TIME on an unlatched channel, and on channel 7 with NUM_LATCH = 4 → no time_out_en, cmd_done still pulses, FSM returns to IDLE.
- Assert rst_n low during GET_TIME EMIT → param_write/cmd_done drop to 0 immediately; the next GET_TIME completes normally.
